cop_rsp_scoreboard: RTL
=======================

# cop_rsp_scoreboard

- Parametrised, synthesisable in-order scoreboard for the co-processor verification flow.
- The golden reference model pushes expected instruction results. The DUT's finished-instruction results pop and compare against the oldest entry.
- Generalises the fixed 4-deep per-field delay chains with:
  - configurable depth and widths;
  - same-cycle bypass;
  - flush;
  - overflow/underflow/timeout detection;
  - saturating pass/fail counters.
- Sits between the model-ISE instance, the DUT response port and the runtime checker in the top-level bench.

## Interface
Parameters:
- DEPTH, 4, expected-entry FIFO depth; power of two, ≥2
- WRES, 3, result field width
- WADDR, 5, GPR address width
- WDATA, 32, GPR data width
- MAX_LAT, 64, cycles the head entry may wait before timeout; ≥1

Ports:
- g_clk  in  1  clock; all state changes on rising edge
- g_resetn  in  1  asynchronous active-low reset
- grm_valid  in  1  push expected entry
- grm_result / grm_rd_wen / grm_rd_addr / grm_rd_data  in  WRES/1/WADDR/WDATA  expected fields
- dut_valid  in  1  DUT result to check
- dut_result / dut_rd_wen / dut_rd_addr / dut_rd_data  in  WRES/1/WADDR/WDATA  DUT fields
- flush  in  1  discard all expected entries (instruction abort)
- clr_err  in  1  clear sticky error flags
- sb_count  out  $clog2(DEPTH)+1  entries held
- sb_full / sb_empty  out  1  sb_count==DEPTH / sb_count==0
- chk_valid  out  1  one-cycle pulse: a compare completed last cycle
- chk_fail  out  1  qualifies chk_valid: compare failed
- chk_field  out  4  failing fields, bit0 result, bit1 rd_wen, bit2 rd_addr, bit3 rd_data
- err_overflow / err_underflow / err_timeout  out  1  sticky error flags
- n_checked  out  32  compares done, saturating
- n_failed  out  16  failed compares, saturating

## Operation
- **Storage:** circular FIFO of {result, rd_wen, rd_addr, rd_data}.
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is held in sb_count.
- **Compare target selection:** when dut_valid=1, the target is:
  - FIFO head if sb_empty=0;
  - else the incoming grm entry if grm_valid=1 (bypass: nothing is written, sb_count unchanged);
  - else no target: underflow.
- **Compare rule:**
  - result and rd_wen are always compared.
  - rd_addr and rd_data are compared only when the expected rd_wen=1; otherwise their chk_field bits are 0.
  - chk_fail = |chk_field.
- **Push and pop:**
  - Push when grm_valid and the entry is not consumed by bypass.
  - Pop when dut_valid and sb_empty=0.
  - Push and pop in the same cycle: sb_count unchanged; legal when full (a pop frees the slot).
- **Overflow:** push while full with no pop → entry dropped, err_overflow←1.
- **Underflow:** dut_valid with no target → err_underflow←1. No chk_valid pulse; counters unchanged.
- **Timeout:**
  - lat_cnt increments each cycle while sb_empty=0 and no pop occurs.
  - It clears on pop, flush or empty.
  - When lat_cnt reaches MAX_LAT, err_timeout←1 and lat_cnt saturates.
- **Flush:**
  - Pointers, sb_count and lat_cnt are cleared.
  - Flush has priority: a same-cycle push is dropped, and a same-cycle dut_valid is treated as underflow only if grm_valid=0; with grm_valid=1 the bypass compare still happens.
  - Sticky flags and counters are retained.
- **clr_err:** clears all three sticky flags.
  - A same-cycle new error wins, so the flag stays set.
- **Counters:**
  - n_checked increments per compare; n_failed increments per failed compare.
  - Both saturate at all-ones.

## Timing
- Reset (async assert, synchronous deassert to g_clk): every output and internal register is zero, except sb_empty=1.
- Latency: chk_valid, chk_fail and chk_field are registered, valid the cycle after dut_valid. Counters update on the same edge.
- sb_count, sb_full, sb_empty and error flags reflect state after the current edge, i.e. one cycle after the causing event.
- No combinational path from any input to any output.
- Throughput: one push and one compare per cycle, indefinitely.
- Reset mid-operation discards all entries; no pulse is emitted.

## Test plan
- Push 3 entries {result 0, wen 1, addr 5, data 0xDEADBEEF}, {0,0,7,0x1}, {1,1,2,0x10}, then 3 matching dut_valid → chk_valid ×3, chk_fail=0, n_checked=3, sb_empty=1.
- Expected {0,1,5,0xDEADBEEF}, DUT data 0xDEADBEEE → chk_fail=1, chk_field=4'b1000, n_failed=1. Expected wen=0 with differing addr/data → chk_fail=0.
- Empty FIFO, grm_valid and dut_valid same cycle with identical fields → chk_fail=0, sb_count stays 0. dut_valid alone while empty → err_underflow=1, no chk_valid.
- DEPTH=4:
  - 5 pushes with no pops → err_overflow=1, sb_count=4.
  - Then push+pop same cycle → sb_count=4, no further error.
  - Then 4 pops → head order matches the first 4 pushes.
- MAX_LAT=8, push 1 entry, no dut_valid for 8 cycles → err_timeout=1. clr_err → 0. flush → sb_empty=1 next cycle, n_checked unchanged.
- Assert g_resetn=0 asynchronously mid-burst with sb_count=3 → all outputs zero and sb_empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cop_rsp_scoreboard.sv
// In-order expected-vs-actual scoreboard: the reference model pushes expected results, the DUT
// pops and compares them against the oldest entry, with bypass, flush, error flags and counters.
module cop_rsp_scoreboard #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned WRES    = 3,
    parameter int unsigned WADDR   = 5,
    parameter int unsigned WDATA   = 32,
    parameter int unsigned MAX_LAT = 64
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    input  logic                       grm_valid,
    input  logic [WRES-1:0]            grm_result,
    input  logic                       grm_rd_wen,
    input  logic [WADDR-1:0]           grm_rd_addr,
    input  logic [WDATA-1:0]           grm_rd_data,
    input  logic                       dut_valid,
    input  logic [WRES-1:0]            dut_result,
    input  logic                       dut_rd_wen,
    input  logic [WADDR-1:0]           dut_rd_addr,
    input  logic [WDATA-1:0]           dut_rd_data,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic [$clog2(DEPTH):0]     sb_count,
    output logic                       sb_full,
    output logic                       sb_empty,
    output logic                       chk_valid,
    output logic                       chk_fail,
    output logic [3:0]                 chk_field,
    output logic                       err_overflow,
    output logic                       err_underflow,
    output logic                       err_timeout,
    output logic [31:0]                n_checked,
    output logic [15:0]                n_failed
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = $clog2(MAX_LAT + 1);
    localparam int unsigned EW = WRES + 1 + WADDR + WDATA;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [LW-1:0] LAT_MAX  = LW'(MAX_LAT);
    localparam logic [LW-1:0] LAT_LAST = LW'(MAX_LAT - 1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          chk_valid_q, chk_valid_d, chk_fail_q, chk_fail_d;
    logic [3:0]    chk_field_q, chk_field_d, field;
    logic          ovf_q, ovf_d, udf_q, udf_d, tmo_q, tmo_d;
    logic [31:0]   n_checked_q, n_checked_d;
    logic [15:0]   n_failed_q, n_failed_d;

    logic          empty, full, no_head, use_head, bypass, underflow, cmp, pop, push, wr;
    logic          overflow, timeout_set;
    logic [EW-1:0] grm_ent, exp_ent;
    logic [WRES-1:0]  exp_result;
    logic             exp_wen;
    logic [WADDR-1:0] exp_addr;
    logic [WDATA-1:0] exp_data;

    assign grm_ent = {grm_result, grm_rd_wen, grm_rd_addr, grm_rd_data};

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        // A flush hides the FIFO from target selection, so only a bypass can still compare.
        no_head   = empty || flush;
        use_head  = dut_valid && !no_head;
        bypass    = dut_valid && no_head && grm_valid;
        underflow = dut_valid && no_head && !grm_valid;
        cmp       = use_head || bypass;
        pop       = use_head;
        push      = grm_valid && !bypass && !flush;
        wr        = push && (!full || pop);
        overflow  = push && full && !pop;

        exp_ent    = use_head ? mem_q[rd_ptr_q] : grm_ent;
        exp_result = exp_ent[EW-1 -: WRES];
        exp_wen    = exp_ent[WADDR+WDATA];
        exp_addr   = exp_ent[WDATA +: WADDR];
        exp_data   = exp_ent[WDATA-1:0];

        field[0] = (exp_result != dut_result);
        field[1] = (exp_wen != dut_rd_wen);
        field[2] = exp_wen && (exp_addr != dut_rd_addr);
        field[3] = exp_wen && (exp_data != dut_rd_data);

        mem_d = mem_q;
        if (wr) begin
            mem_d[wr_ptr_q] = grm_ent;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr)  wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            if (wr && !pop)      count_d = count_q + CW'(1);
            else if (pop && !wr) count_d = count_q - CW'(1);
        end

        // Flag fires only on the step into MAX_LAT so clr_err can clear it while saturated.
        lat_d       = lat_q;
        timeout_set = 1'b0;
        if (flush || pop || empty) begin
            lat_d = '0;
        end else if (lat_q != LAT_MAX) begin
            lat_d       = lat_q + LW'(1);
            timeout_set = (lat_q == LAT_LAST);
        end

        chk_valid_d = cmp;
        chk_fail_d  = cmp && (|field);
        chk_field_d = cmp ? field : 4'b0;

        ovf_d = overflow  || (ovf_q && !clr_err);
        udf_d = underflow || (udf_q && !clr_err);
        tmo_d = timeout_set || (tmo_q && !clr_err);

        n_checked_d = n_checked_q;
        n_failed_d  = n_failed_q;
        if (cmp && !(&n_checked_q))            n_checked_d = n_checked_q + 32'd1;
        if (cmp && (|field) && !(&n_failed_q)) n_failed_d  = n_failed_q + 16'd1;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lat_q       <= '0;
            chk_valid_q <= 1'b0;
            chk_fail_q  <= 1'b0;
            chk_field_q <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            n_checked_q <= '0;
            n_failed_q  <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lat_q       <= lat_d;
            chk_valid_q <= chk_valid_d;
            chk_fail_q  <= chk_fail_d;
            chk_field_q <= chk_field_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            tmo_q       <= tmo_d;
            n_checked_q <= n_checked_d;
            n_failed_q  <= n_failed_d;
        end
    end

    assign sb_count      = count_q;
    assign sb_full       = (count_q == FULL_CNT);
    assign sb_empty      = (count_q == '0);
    assign chk_valid     = chk_valid_q;
    assign chk_fail      = chk_fail_q;
    assign chk_field     = chk_field_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;
    assign err_timeout   = tmo_q;
    assign n_checked     = n_checked_q;
    assign n_failed      = n_failed_q;

endmodule
